// File: rtl/rhythm_pkg.sv
// Shared types, key codes and BCD helpers for the rhythm-game score path.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } game_state_t;

  localparam logic [7:0]  KEY_START = 8'h2c;
  localparam logic [7:0]  KEY_RESET = 8'h01;
  localparam logic [15:0] BCD_SAT   = 16'h9999;

  function automatic logic [15:0] bcd_to_bin(input logic [15:0] bcd);
    return ({12'd0, bcd[15:12]} * 16'd1000) + ({12'd0, bcd[11:8]} * 16'd100)
         + ({12'd0, bcd[7:4]} * 16'd10) + {12'd0, bcd[3:0]};
  endfunction

  // Shift-and-add-3 conversion of a value known to be at most 9999.
  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [29:0] sr;
    sr = {16'd0, bin};
    for (int unsigned i = 0; i < 14; i++) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (sr[14+4*d +: 4] >= 4'd5)
          sr[14+4*d +: 4] = sr[14+4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    return sr[29:14];
  endfunction

endpackage

// File: rtl/bcd_add4.sv
// Combinational four-digit BCD accumulate of a small binary addend, clamped at 9999.
module bcd_add4
  import rhythm_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic [15:0]   augend,
  input  logic [AW-1:0] addend,
  output logic [15:0]   sum
);

  logic [15:0] bin_sum;

  always_comb begin
    bin_sum = bcd_to_bin(augend) + 16'(addend);
    sum     = (bin_sum > 16'd9999) ? BCD_SAT : bin_to_bcd(bin_sum[13:0]);
  end

endmodule

// File: rtl/score_tally.sv
// Per-frame score, combo and game-phase tracker fed by the lane droppers.
module score_tally
  import rhythm_pkg::*;
#(
  parameter int unsigned LANES       = 24,
  parameter int unsigned SONG_FRAMES = 3000,
  parameter int unsigned COMBO_BONUS = 10
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [7:0]       keycode,
  input  logic [LANES-1:0] score_flags,
  input  logic [LANES-1:0] miss_flags,
  output logic [15:0]      score_bcd,
  output logic [7:0]       combo,
  output logic [7:0]       max_combo,
  output logic [1:0]       game_state,
  output logic             hit_pulse
);

  localparam int unsigned KW = $clog2(LANES + 1);
  localparam int unsigned AW = KW + 1;
  localparam int unsigned FW = $clog2(SONG_FRAMES + 1);

  game_state_t      state;
  logic [FW-1:0]    frame_cnt;
  logic [LANES-1:0] prev_score, prev_miss;
  logic [LANES-1:0] new_hit, new_miss;
  logic [KW-1:0]    hit_cnt;
  logic [AW-1:0]    points;
  logic [15:0]      score_next;
  logic [15:0]      combo_sum;
  logic [7:0]       combo_next, max_next;
  logic             clear_all;

  assign game_state = state;
  assign new_hit    = score_flags & ~prev_score;
  assign new_miss   = miss_flags & ~prev_miss;

  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++)
      hit_cnt = hit_cnt + KW'(new_hit[i]);
  end

  always_comb begin
    points     = (32'(combo) < COMBO_BONUS) ? {1'b0, hit_cnt} : {hit_cnt, 1'b0};
    combo_sum  = 16'(combo) + 16'(hit_cnt);
    combo_next = (combo_sum > 16'd255) ? 8'hff : combo_sum[7:0];
    max_next   = (combo_next > max_combo) ? combo_next : max_combo;
  end

  bcd_add4 #(.AW(AW)) u_bcd_add (
    .augend (score_bcd),
    .addend (points),
    .sum    (score_next)
  );

  // Idle and the abort key both zero the datapath, so one clear term covers them with Reset.
  assign clear_all = Reset || (state == ST_IDLE) || (keycode == KEY_RESET);

  always_ff @(posedge frame_clk) begin
    if (clear_all) begin
      score_bcd  <= '0;
      combo      <= '0;
      max_combo  <= '0;
      frame_cnt  <= '0;
      hit_pulse  <= 1'b0;
      prev_score <= '0;
      prev_miss  <= '0;
    end else if (state == ST_PLAY) begin
      score_bcd  <= score_next;
      max_combo  <= max_next;
      combo      <= (|new_miss) ? 8'd0 : combo_next;
      hit_pulse  <= (hit_cnt != '0);
      prev_score <= score_flags;
      prev_miss  <= miss_flags;
      frame_cnt  <= frame_cnt + FW'(1);
    end else begin
      hit_pulse  <= 1'b0;
    end

    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (keycode == KEY_START) state <= ST_PLAY;
        ST_PLAY: begin
          if (keycode == KEY_RESET)
            state <= ST_IDLE;
          else if (frame_cnt == FW'(SONG_FRAMES - 1))
            state <= ST_DONE;
        end
        ST_DONE: if (keycode == KEY_RESET) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_tally.sv
// Randomised and directed checks of score_tally against an integer game model.
module tb_score_tally;

  localparam int unsigned LANES       = 24;
  localparam int unsigned SONG_FRAMES = 3000;
  localparam int unsigned COMBO_BONUS = 10;

  logic             frame_clk = 1'b0;
  logic             Reset = 1'b1;
  logic [7:0]       keycode = 8'h00;
  logic [LANES-1:0] score_flags = '0;
  logic [LANES-1:0] miss_flags = '0;
  logic [15:0]      score_bcd;
  logic [7:0]       combo, max_combo;
  logic [1:0]       game_state;
  logic             hit_pulse;

  score_tally #(
    .LANES(LANES), .SONG_FRAMES(SONG_FRAMES), .COMBO_BONUS(COMBO_BONUS)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .score_flags (score_flags),
    .miss_flags  (miss_flags),
    .score_bcd   (score_bcd),
    .combo       (combo),
    .max_combo   (max_combo),
    .game_state  (game_state),
    .hit_pulse   (hit_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Game model: state 0/1/2, decimal score, integer combo counters.
  int               m_state, m_score, m_combo, m_max, m_fc;
  bit               m_pulse;
  logic [LANES-1:0] m_prev_s, m_prev_m;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [34:0] expected_vec();
    return {2'(m_state), to_bcd(m_score), 8'(m_combo), 8'(m_max), m_pulse};
  endfunction

  function automatic logic [34:0] observed_vec();
    return {game_state, score_bcd, combo, max_combo, hit_pulse};
  endfunction

  task automatic model_clear();
    m_score = 0; m_combo = 0; m_max = 0; m_fc = 0; m_pulse = 0;
    m_prev_s = '0; m_prev_m = '0;
  endtask

  task automatic step(input logic [LANES-1:0] sf, input logic [LANES-1:0] mf,
                      input logic [7:0] key, input logic rst);
    logic [LANES-1:0] hits, misses;
    int k, pts, c;
    score_flags = sf; miss_flags = mf; keycode = key; Reset = rst;
    @(posedge frame_clk);
    if (rst) begin
      model_clear(); m_state = 0;
    end else if (m_state == 0) begin
      model_clear();
      if (key == 8'h2c) m_state = 1;
    end else if (m_state == 1) begin
      if (key == 8'h01) begin
        model_clear(); m_state = 0;
      end else begin
        hits   = sf & ~m_prev_s;
        misses = mf & ~m_prev_m;
        k      = $countones(hits);
        pts    = (m_combo < COMBO_BONUS) ? k : 2 * k;
        m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
        c       = (m_combo + k > 255) ? 255 : m_combo + k;
        if (c > m_max) m_max = c;
        m_combo  = (misses != 0) ? 0 : c;
        m_pulse  = (k != 0);
        m_prev_s = sf; m_prev_m = mf;
        if (m_fc == SONG_FRAMES - 1) m_state = 2;
        m_fc++;
      end
    end else begin
      m_pulse = 0;
      if (key == 8'h01) begin
        model_clear(); m_state = 0;
      end
    end
    #1;
  endtask

  task automatic new_game();
    step('0, '0, 8'h01, 1'b0);
    step('0, '0, 8'h00, 1'b0);
    step('0, '0, 8'h2c, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) step('0, '0, 8'h00, 1'b1);
    n_cmp++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", game_state); end
    n_cmp++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
    n_cmp++; if ({combo, max_combo, hit_pulse} !== 17'd0) begin
      n_fail++; $display("FAIL reset_counters: combo %0d max %0d pulse %0b want 0", combo, max_combo, hit_pulse); end
    step('0, '0, 8'h00, 1'b0);
  endtask

  task automatic test_start();
    step('0, '0, 8'h2c, 1'b0);
    n_cmp++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", game_state); end
    n_cmp++; if ({score_bcd, combo, max_combo, hit_pulse} !== 33'd0) begin
      n_fail++; $display("FAIL start_counters: score %h combo %0d max %0d want 0", score_bcd, combo, max_combo); end
    step('0, '0, 8'h00, 1'b0);
    n_cmp++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL start_hold: got %0d want 1", game_state); end
  endtask

  task automatic test_single_hit();
    int pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(LANES'(1) << 3, '0, 8'h00, 1'b0);
      if (hit_pulse === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
    n_cmp++; if (score_bcd !== 16'h0001) begin n_fail++; $display("FAIL single_score: got %h want 0001", score_bcd); end
    n_cmp++; if (combo !== 8'd1 || max_combo !== 8'd1) begin
      n_fail++; $display("FAIL single_combo: combo %0d max %0d want 1/1", combo, max_combo); end
    step('0, '0, 8'h00, 1'b0);
  endtask

  task automatic test_bonus();
    new_game();
    for (int i = 0; i < 12; i++) begin
      step(LANES'(1) << i, '0, 8'h00, 1'b0);
      step('0, '0, 8'h00, 1'b0);
    end
    n_cmp++; if (score_bcd !== 16'h0014) begin n_fail++; $display("FAIL bonus_score: got %h want 0014", score_bcd); end
    n_cmp++; if (combo !== 8'd12 || max_combo !== 8'd12) begin
      n_fail++; $display("FAIL bonus_combo: combo %0d max %0d want 12/12", combo, max_combo); end
  endtask

  task automatic test_simultaneous();
    new_game();
    for (int i = 0; i < 5; i++) begin
      step(LANES'(1) << (8 + i), '0, 8'h00, 1'b0);
      step('0, '0, 8'h00, 1'b0);
    end
    step(LANES'(7), LANES'(1) << 4, 8'h00, 1'b0);
    n_cmp++; if (score_bcd !== 16'h0008) begin n_fail++; $display("FAIL simul_score: got %h want 0008", score_bcd); end
    n_cmp++; if (combo !== 8'd0 || max_combo !== 8'd8 || hit_pulse !== 1'b1) begin
      n_fail++; $display("FAIL simul_combo: combo %0d max %0d pulse %0b want 0/8/1", combo, max_combo, hit_pulse); end
    step('0, '0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [LANES-1:0] sf = '0, mf = '0;
    logic [7:0] key;
    int r;
    new_game();
    for (int cyc = 0; cyc < 600; cyc++) begin
      sf = sf ^ LANES'($urandom & $urandom & $urandom);
      mf = mf ^ LANES'($urandom & $urandom & $urandom & $urandom);
      r = $urandom_range(0, 199);
      key = (r == 0) ? 8'h01 : (r < 6) ? 8'h2c : 8'h55;
      step(sf, mf, key, ($urandom_range(0, 299) == 0));
      n_cmp++;
      if (observed_vec() !== expected_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", cyc, observed_vec(), expected_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int k;
    new_game();
    for (int i = 0; i < 10; i++) begin
      step(LANES'(1), '0, 8'h00, 1'b0);
      step('0, '0, 8'h00, 1'b0);
    end
    for (int n = 0; n < 1000 && m_score < 9998; n++) begin
      k = (9998 - m_score) / 2;
      if (k > int'(LANES)) k = LANES;
      step(LANES'((64'd1 << k) - 64'd1), '0, 8'h00, 1'b0);
      n_cmp++;
      if (observed_vec() !== expected_vec()) begin
        n_fail++; $display("FAIL preload step %0d: got %h want %h", n, observed_vec(), expected_vec());
      end
      step('0, '0, 8'h00, 1'b0);
    end
    n_cmp++; if (score_bcd !== 16'h9998) begin n_fail++; $display("FAIL sat_preload: got %h want 9998", score_bcd); end
    step(LANES'(1) << 5, '0, 8'h00, 1'b0);
    n_cmp++; if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_clamp: got %h want 9999", score_bcd); end
    step('0, '0, 8'h00, 1'b0);
    step(LANES'(1) << 6, '0, 8'h00, 1'b0);
    n_cmp++; if (score_bcd !== 16'h9999 || observed_vec() !== expected_vec()) begin
      n_fail++; $display("FAIL sat_hold: got %h want %h", observed_vec(), expected_vec()); end
    step('0, '0, 8'h00, 1'b0);
  endtask

  task automatic test_done();
    logic [34:0] snap;
    int guard = 0;
    while (game_state !== 2'd2 && guard < SONG_FRAMES + 10) begin
      step('0, '0, 8'h00, 1'b0);
      guard++;
      n_cmp++;
      if (game_state !== 2'(m_state)) begin
        n_fail++; $display("FAIL done_timing step %0d: got %0d want %0d", guard, game_state, m_state);
      end
    end
    n_cmp++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL done_reached: got %0d want 2", game_state); end
    snap = observed_vec();
    for (int i = 0; i < 20; i++) begin
      step(LANES'($urandom), LANES'($urandom), 8'h2c, 1'b0);
      n_cmp++;
      if (observed_vec() !== snap) begin
        n_fail++; $display("FAIL done_frozen %0d: got %h want %h", i, observed_vec(), snap);
      end
    end
    step('0, '0, 8'h01, 1'b0);
    n_cmp++; if (observed_vec() !== 35'd0) begin
      n_fail++; $display("FAIL done_exit: got %h want 0", observed_vec()); end
  endtask

  task automatic test_reset_mid_play();
    new_game();
    for (int i = 0; i < 4; i++) begin
      step(LANES'(1) << (i + 1), '0, 8'h00, 1'b0);
      step('0, '0, 8'h00, 1'b0);
    end
    step(LANES'(1) << 7, '0, 8'h00, 1'b1);
    n_cmp++; if (observed_vec() !== 35'd0) begin
      n_fail++; $display("FAIL reset_mid_play: got %h want 0", observed_vec()); end
    step('0, '0, 8'h00, 1'b0);
  endtask

  initial begin
    m_state = 0;
    model_clear();
    test_reset();
    test_start();
    test_single_hit();
    test_bonus();
    test_simultaneous();
    test_random();
    test_saturation();
    test_done();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
